dwconv_sched: RTL and testbench

DWCONV_SCHED -- requirements
Module: dwconv_sched

---
 rtl/dwconv_pkg.sv | 23 ++
 rtl/dwconv_window_cnt.sv | 104 ++++++++++
 rtl/dwconv_sched.sv | 165 ++++++++++++++++
 tb/tb_dwconv_sched.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/dwconv_pkg.sv
// Shared definitions for the depthwise-convolution scheduler and datapath:
// FSM state encoding, default geometry and a width helper for counters.
package dwconv_pkg;

    localparam int DW_ROWS        = 62;
    localparam int DW_COLS        = 65;
    localparam int DW_CHANNELS    = 16;
    localparam int DW_KERNEL_SIZE = 3;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_TAP   = 3'd1,
        ST_DRAIN = 3'd2,
        ST_WRITE = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    // Index width for a counter over 0..n-1; never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/dwconv_window_cnt.sv
// Nested traversal counters for the depthwise scheduler.
// Pixel order is channel, row, column; kernel order is ki then kj.
// The kernel pair advances on i_inc and wraps by itself after the last tap;
// the pixel triple advances only on i_pix_inc, so the output coordinate stays
// valid through DRAIN and WRITE while the kernel pair sits back at 0.
// Also derives the signed input coordinate of the current tap and its pad flag.
module dwconv_window_cnt
    import dwconv_pkg::*;
#(
    parameter int ROWS        = DW_ROWS,
    parameter int COLS        = DW_COLS,
    parameter int CHANNELS    = DW_CHANNELS,
    parameter int KERNEL_SIZE = DW_KERNEL_SIZE
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         i_clr,
    input  logic                         i_inc,
    input  logic                         i_pix_inc,
    output logic [cnt_w(CHANNELS)-1:0]    o_ch,
    output logic [cnt_w(ROWS)-1:0]        o_row,
    output logic [cnt_w(COLS)-1:0]        o_col,
    output logic [cnt_w(KERNEL_SIZE)-1:0] o_ki,
    output logic [cnt_w(KERNEL_SIZE)-1:0] o_kj,
    output logic [cnt_w(ROWS)-1:0]        o_in_row,
    output logic [cnt_w(COLS)-1:0]        o_in_col,
    output logic                         o_pad,
    output logic                         o_pix_last,
    output logic                         o_frame_last
);

    localparam int CHW  = cnt_w(CHANNELS);
    localparam int RW   = cnt_w(ROWS);
    localparam int CLW  = cnt_w(COLS);
    localparam int KW   = cnt_w(KERNEL_SIZE);
    localparam int HALF = KERNEL_SIZE / 2;

    logic [CHW-1:0] r_ch;
    logic [RW-1:0]  r_row;
    logic [CLW-1:0] r_col;
    logic [KW-1:0]  r_ki;
    logic [KW-1:0]  r_kj;

    logic w_ch_last, w_row_last, w_col_last, w_ki_last, w_kj_last;
    int   w_in_r;
    int   w_in_c;

    assign w_ch_last  = (r_ch  == CHW'(CHANNELS - 1));
    assign w_row_last = (r_row == RW'(ROWS - 1));
    assign w_col_last = (r_col == CLW'(COLS - 1));
    assign w_ki_last  = (r_ki  == KW'(KERNEL_SIZE - 1));
    assign w_kj_last  = (r_kj  == KW'(KERNEL_SIZE - 1));

    // Kernel and pixel counters; each wraps only when its outer index steps.
    always_ff @(posedge clk) begin
        if (!rst_n || i_clr) begin
            r_ch  <= '0;
            r_row <= '0;
            r_col <= '0;
            r_ki  <= '0;
            r_kj  <= '0;
        end else begin
            if (i_inc) begin
                if (w_kj_last) begin
                    r_kj <= '0;
                    r_ki <= w_ki_last ? '0 : r_ki + 1'b1;
                end else begin
                    r_kj <= r_kj + 1'b1;
                end
            end
            if (i_pix_inc) begin
                if (w_col_last) begin
                    r_col <= '0;
                    if (w_row_last) begin
                        r_row <= '0;
                        r_ch  <= w_ch_last ? '0 : r_ch + 1'b1;
                    end else begin
                        r_row <= r_row + 1'b1;
                    end
                end else begin
                    r_col <= r_col + 1'b1;
                end
            end
        end
    end

    // Signed input coordinate of the tap; outside the map means a zero tap.
    always_comb begin
        w_in_r = int'(r_row) + int'(r_ki) - HALF;
        w_in_c = int'(r_col) + int'(r_kj) - HALF;
        o_pad  = (w_in_r < 0) || (w_in_r >= ROWS) || (w_in_c < 0) || (w_in_c >= COLS);
        o_in_row = o_pad ? '0 : w_in_r[RW-1:0];
        o_in_col = o_pad ? '0 : w_in_c[CLW-1:0];
    end

    assign o_ch         = r_ch;
    assign o_row        = r_row;
    assign o_col        = r_col;
    assign o_ki         = r_ki;
    assign o_kj         = r_kj;
    assign o_pix_last   = w_ki_last && w_kj_last;
    assign o_frame_last = w_ch_last && w_row_last && w_col_last;

endmodule

// File: rtl/dwconv_sched.sv
// Depthwise-convolution tap scheduler: walks every output pixel of every
// channel, issues KERNEL_SIZE^2 taps to the MAC engine, waits one cycle for the
// accumulate, then holds the pixel for writeback until the sink accepts it.
// KERNEL_SIZE must be odd so the window centres on the output pixel.
// Optional build macro DWCONV_SCHED_PERF_EN adds stall_cnt, a count of WRITE
// cycles spent waiting on wr_ready since the last accepted start.
//
//   state | meaning
//   IDLE  | waiting for start
//   TAP   | one kernel tap per cycle for the current pixel
//   DRAIN | one cycle for the MAC accumulate to settle
//   WRITE | pixel offered on wr_valid until wr_ready
//   DONE  | one-cycle done pulse, then back to IDLE
module dwconv_sched
    import dwconv_pkg::*;
#(
    parameter int ROWS        = DW_ROWS,
    parameter int COLS        = DW_COLS,
    parameter int CHANNELS    = DW_CHANNELS,
    parameter int KERNEL_SIZE = DW_KERNEL_SIZE
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    output logic                         busy,
    output logic                         done,
    output logic                         tap_valid,
    output logic [cnt_w(ROWS)-1:0]        tap_row,
    output logic [cnt_w(COLS)-1:0]        tap_col,
    output logic [cnt_w(CHANNELS)-1:0]    tap_ch,
    output logic [cnt_w(KERNEL_SIZE)-1:0] tap_ki,
    output logic [cnt_w(KERNEL_SIZE)-1:0] tap_kj,
    output logic                         tap_pad,
    output logic                         acc_clr,
    output logic                         wr_valid,
    input  logic                         wr_ready,
    output logic [cnt_w(ROWS)-1:0]        out_row,
    output logic [cnt_w(COLS)-1:0]        out_col,
    output logic [cnt_w(CHANNELS)-1:0]    out_ch
`ifdef DWCONV_SCHED_PERF_EN
    ,
    output logic [31:0]                  stall_cnt
`endif
);

    localparam int CHW = cnt_w(CHANNELS);
    localparam int RW  = cnt_w(ROWS);
    localparam int CLW = cnt_w(COLS);
    localparam int KW  = cnt_w(KERNEL_SIZE);

    state_t r_state;
    state_t w_state_nxt;

    logic           w_clr, w_inc, w_pix_inc, w_start_acc;
    logic           w_pad, w_pix_last, w_frame_last;
    logic [CHW-1:0] w_ch;
    logic [RW-1:0]  w_row, w_in_row;
    logic [CLW-1:0] w_col, w_in_col;
    logic [KW-1:0]  w_ki, w_kj;

    dwconv_window_cnt #(
        .ROWS        (ROWS),
        .COLS        (COLS),
        .CHANNELS    (CHANNELS),
        .KERNEL_SIZE (KERNEL_SIZE)
    ) u_window_cnt (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_clr        (w_clr),
        .i_inc        (w_inc),
        .i_pix_inc    (w_pix_inc),
        .o_ch         (w_ch),
        .o_row        (w_row),
        .o_col        (w_col),
        .o_ki         (w_ki),
        .o_kj         (w_kj),
        .o_in_row     (w_in_row),
        .o_in_col     (w_in_col),
        .o_pad        (w_pad),
        .o_pix_last   (w_pix_last),
        .o_frame_last (w_frame_last)
    );

    assign w_start_acc = (r_state == ST_IDLE) && start;

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and counter strobes.
    always_comb begin
        w_state_nxt = r_state;
        w_clr       = 1'b0;
        w_inc       = 1'b0;
        w_pix_inc   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_clr       = 1'b1;
                    w_state_nxt = ST_TAP;
                end
            end
            ST_TAP: begin
                w_inc = 1'b1;
                if (w_pix_last) begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                w_state_nxt = ST_WRITE;
            end
            ST_WRITE: begin
                if (wr_ready) begin
                    w_pix_inc   = 1'b1;
                    w_state_nxt = w_frame_last ? ST_DONE : ST_TAP;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign busy      = (r_state == ST_TAP) || (r_state == ST_DRAIN) || (r_state == ST_WRITE);
    assign done      = (r_state == ST_DONE);
    assign tap_valid = (r_state == ST_TAP);
    assign tap_pad   = tap_valid && w_pad;
    assign acc_clr   = tap_valid && (w_ki == '0) && (w_kj == '0);
    assign wr_valid  = (r_state == ST_WRITE);
    assign tap_row   = w_in_row;
    assign tap_col   = w_in_col;
    assign tap_ch    = w_ch;
    assign tap_ki    = w_ki;
    assign tap_kj    = w_kj;
    assign out_row   = w_row;
    assign out_col   = w_col;
    assign out_ch    = w_ch;

`ifdef DWCONV_SCHED_PERF_EN
    logic [31:0] r_stall_cnt;

    // Count writeback cycles lost to sink backpressure within the current pass.
    always_ff @(posedge clk) begin
        if (!rst_n || w_start_acc) begin
            r_stall_cnt <= '0;
        end else if ((r_state == ST_WRITE) && !wr_ready) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign stall_cnt = r_stall_cnt;
`else
    logic w_unused_start_acc;
    assign w_unused_start_acc = w_start_acc;
`endif

endmodule

// File: tb/tb_dwconv_sched.sv
// Directed bench for dwconv_sched on a reduced geometry (6x5 map, 3 channels,
// 3x3 kernel) so every pixel of several frames is walked cycle by cycle.
// Expected output coordinates are queued at start and popped on handshake.
module tb_dwconv_sched;

    localparam int ROWS      = 6;
    localparam int COLS      = 5;
    localparam int CHS       = 3;
    localparam int K         = 3;
    localparam int RW        = $clog2(ROWS);
    localparam int CLW       = $clog2(COLS);
    localparam int CHW       = $clog2(CHS);
    localparam int KW        = $clog2(K);
    localparam int NPIX      = ROWS * COLS * CHS;
    localparam int HALF      = K / 2;
    localparam int STALL_LEN = 5;

    logic           clk = 1'b0;
    logic           rst_n, start, wr_ready;
    logic           busy, done, tap_valid, tap_pad, acc_clr, wr_valid;
    logic [RW-1:0]  tap_row, out_row;
    logic [CLW-1:0] tap_col, out_col;
    logic [CHW-1:0] tap_ch, out_ch;
    logic [KW-1:0]  tap_ki, tap_kj;
`ifdef DWCONV_SCHED_PERF_EN
    logic [31:0]    stall_cnt;
`endif

    int          n_chk = 0;
    int          n_err = 0;
    logic [63:0] sb[$];

    always #5 clk = ~clk;

    dwconv_sched #(
        .ROWS        (ROWS),
        .COLS        (COLS),
        .CHANNELS    (CHS),
        .KERNEL_SIZE (K)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .tap_valid (tap_valid),
        .tap_row   (tap_row),
        .tap_col   (tap_col),
        .tap_ch    (tap_ch),
        .tap_ki    (tap_ki),
        .tap_kj    (tap_kj),
        .tap_pad   (tap_pad),
        .acc_clr   (acc_clr),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .out_row   (out_row),
        .out_col   (out_col),
        .out_ch    (out_ch)
`ifdef DWCONV_SCHED_PERF_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One output pixel: n_taps taps checked against the window model, then
    // DRAIN, WRITE with optional backpressure, and the handshake.
    task automatic run_pixel(input int ch, input int r, input int c, input int n_taps,
                             input int n_stall, input bit pulse, output int n_pad_seen);
        int          rr, cc;
        bit          pad;
        logic [63:0] exp_wr, exp_px;
        n_pad_seen = 0;
        for (int ki = 0; ki < K; ki++) begin
            for (int kj = 0; kj < K; kj++) begin
                if (ki * K + kj >= n_taps) return;
                rr  = r + ki - HALF;
                cc  = c + kj - HALF;
                pad = (rr < 0) || (rr >= ROWS) || (cc < 0) || (cc >= COLS);
                if (pad) begin
                    rr = 0;
                    cc = 0;
                end
                if (tap_pad === 1'b1) n_pad_seen++;
                chk($sformatf("tap ch%0d r%0d c%0d k%0d%0d", ch, r, c, ki, kj),
                    64'({tap_valid, tap_pad, acc_clr, busy, done, wr_valid,
                         tap_ch, tap_row, tap_col, tap_ki, tap_kj}),
                    64'({1'b1, pad, (ki == 0 && kj == 0), 1'b1, 1'b0, 1'b0,
                         CHW'(ch), RW'(rr), CLW'(cc), KW'(ki), KW'(kj)}));
                if (pulse && ki == 1 && kj == 1) start = 1'b1;
                tick();
                start = 1'b0;
            end
        end
        chk($sformatf("drain ch%0d r%0d c%0d", ch, r, c),
            64'({tap_valid, wr_valid, busy, done}), 64'(4'b0010));
        tick();
        exp_wr = 64'({4'b1010, CHW'(ch), RW'(r), CLW'(c)});
        chk($sformatf("write ch%0d r%0d c%0d", ch, r, c),
            64'({wr_valid, tap_valid, busy, done, out_ch, out_row, out_col}), exp_wr);
        if (n_stall > 0) begin
            wr_ready = 1'b0;
            for (int s = 0; s < n_stall; s++) begin
                if (pulse && s == 1) start = 1'b1;
                tick();
                start = 1'b0;
                chk($sformatf("stall_hold %0d", s),
                    64'({wr_valid, tap_valid, busy, done, out_ch, out_row, out_col}), exp_wr);
            end
`ifdef DWCONV_SCHED_PERF_EN
            chk("stall_cnt", 64'(stall_cnt), 64'(n_stall));
`endif
            wr_ready = 1'b1;
        end
        exp_px = (sb.size() > 0) ? sb.pop_front() : '1;
        chk($sformatf("handshake ch%0d r%0d c%0d", ch, r, c),
            64'({out_ch, out_row, out_col}), exp_px);
        tick();
    endtask

    // A full pass; optionally stall one pixel, pulse start while busy on two
    // pixels, or pull reset part-way through pixel abort_idx.
    task automatic run_frame(input int stall_idx, input int pulse_a, input int pulse_b,
                             input int abort_idx);
        int idx;
        int npad;
        idx = 0;
        sb.delete();
        for (int ch = 0; ch < CHS; ch++)
            for (int r = 0; r < ROWS; r++)
                for (int c = 0; c < COLS; c++)
                    sb.push_back(64'({CHW'(ch), RW'(r), CLW'(c)}));
        start = 1'b1;
        tick();
        start = 1'b0;
`ifdef DWCONV_SCHED_PERF_EN
        chk("stall_cnt_clear", 64'(stall_cnt), 64'd0);
`endif
        for (int ch = 0; ch < CHS; ch++) begin
            for (int r = 0; r < ROWS; r++) begin
                for (int c = 0; c < COLS; c++) begin
                    if (idx == abort_idx) begin
                        run_pixel(ch, r, c, 4, 0, 1'b0, npad);
                        rst_n = 1'b0;
                        tick();
                        chk("abort_idle",
                            64'({busy, done, tap_valid, tap_pad, acc_clr, wr_valid}), 64'd0);
                        rst_n = 1'b1;
                        for (int i = 0; i < 15; i++) begin
                            tick();
                            chk("abort_quiet", 64'({busy, done, tap_valid, wr_valid}), 64'd0);
                        end
                        return;
                    end
                    run_pixel(ch, r, c, K * K, (idx == stall_idx) ? STALL_LEN : 0,
                              (idx == pulse_a) || (idx == pulse_b), npad);
                    if (idx == 0)        chk("pad_count_first", 64'(npad), 64'd5);
                    if (idx == NPIX - 1) chk("pad_count_corner", 64'(npad), 64'd5);
                    idx++;
                end
            end
        end
        chk("done_pulse", 64'({done, busy, tap_valid, wr_valid}), 64'(4'b1000));
        tick();
        chk("done_single", 64'({done, busy, tap_valid, wr_valid}), 64'd0);
    endtask

    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        wr_ready = 1'b1;
        tick();
        tick();
        chk("reset_outputs", 64'({busy, done, tap_valid, tap_pad, acc_clr, wr_valid}), 64'd0);
`ifdef DWCONV_SCHED_PERF_EN
        chk("reset_stall_cnt", 64'(stall_cnt), 64'd0);
`endif
        rst_n = 1'b1;
        tick();
        chk("idle_quiet", 64'({busy, done, tap_valid, wr_valid}), 64'd0);

        run_frame(-1, -1, -1, -1);
        run_frame(3, 3, 7, -1);
        run_frame(-1, -1, -1, 20);
        run_frame(-1, -1, -1, -1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
